// File: rtl/serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// serial_pattern_tx
//   Parallel-to-serial bit-pattern transmitter. A frame (word + bit count) is
//   taken over a valid/ready handshake and shifted out one bit per clock on
//   ser_out. Each frame is followed by GAP idle cycles and a one-cycle done
//   pulse. Typically drives the 1-bit 'in' input of a sequence detector.
//
// Handshake: a frame is accepted on a rising edge where in_valid && in_ready.
//   in_ready is high only in IDLE. in_valid while busy is simply ignored
//   (there is no queue). in_data/in_len are sampled only at acceptance.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high (wins over in_valid)
//   in_valid   in   1      frame request valid
//   in_ready   out  1      block can accept a frame this cycle (state == IDLE)
//   in_data    in   DW     frame bits; only the low len bits are sent
//   in_len     in   LW     bits to send, values above DW clamp to DW
//   ser_out    out  1      serial data bit (registered, 0 when ser_valid=0)
//   ser_valid  out  1      ser_out carries a frame bit this cycle
//   busy       out  1      frame in progress (SHIFT or GAP)
//   done       out  1      one-cycle pulse: frame complete
//   dbg_state  out  2      current FSM state (0=IDLE, 1=SHIFT, 2=GAP)
// -----------------------------------------------------------------------------
module serial_pattern_tx #(
  parameter int DW        = 16,
  parameter int LW        = $clog2(DW + 1),
  parameter int GAP       = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [LW-1:0] in_len,
  output logic          ser_out,
  output logic          ser_valid,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Gap counter holds "GAP cycles still to spend after this one".
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);

  state_t        r_state;
  logic [DW-1:0] r_shift;
  logic [LW-1:0] r_bit_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic          r_ser_out;
  logic          r_ser_valid;
  logic          r_done;

  logic [LW-1:0] w_len;
  logic [DW-1:0] w_load;
  logic          w_accept;

  // Clamp the requested length to the word width.
  assign w_len    = (in_len > LW'(DW)) ? LW'(DW) : in_len;
  assign w_accept = in_valid && (r_state == S_IDLE);

  // Align the frame so the next bit to send always sits at the shift-out end:
  // MSB-first left-justifies the len-bit field (bit len-1 lands in DW-1),
  // LSB-first uses the word as-is and shifts right.
  always_comb begin
    w_load = in_data;
    if (MSB_FIRST) begin
      w_load = in_data << (DW - int'(w_len));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_len != '0) begin
              // First bit goes out in the cycle right after acceptance;
              // r_bit_cnt counts the bits still to follow it.
              r_state     <= S_SHIFT;
              r_ser_valid <= 1'b1;
              r_ser_out   <= MSB_FIRST ? w_load[DW-1] : w_load[0];
              r_shift     <= MSB_FIRST ? (w_load << 1) : (w_load >> 1);
              r_bit_cnt   <= w_len - LW'(1);
            end else if (GAP > 0) begin
              r_state   <= S_GAP;
              r_gap_cnt <= GAP_LAST;
            end else begin
              r_done <= 1'b1;
            end
          end
        end

        S_SHIFT: begin
          if (r_bit_cnt == '0) begin
            // Last bit was on the line this cycle.
            r_ser_valid <= 1'b0;
            r_ser_out   <= 1'b0;
            if (GAP > 0) begin
              r_state   <= S_GAP;
              r_gap_cnt <= GAP_LAST;
            end else begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end else begin
            r_ser_out <= MSB_FIRST ? r_shift[DW-1] : r_shift[0];
            r_shift   <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
            r_bit_cnt <= r_bit_cnt - LW'(1);
          end
        end

        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_SHIFT) || (r_state == S_GAP);
  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_pattern_tx
//   Drives two transmitters (MSB-first and LSB-first, GAP=2) with the same
//   stimulus and checks every cycle of every frame against a frame-level
//   reference: the expected bit list is built straight from the data word and
//   clamped length, and the expected cycle timeline (bits, gap, done) from
//   len and GAP.
// -----------------------------------------------------------------------------
module tb_serial_pattern_tx;

  localparam int DW  = 16;
  localparam int LW  = 5;
  localparam int GAP = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst      = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic [LW-1:0] in_len   = '0;

  logic       m_ready, m_out, m_valid, m_busy, m_done;
  logic       l_ready, l_out, l_valid, l_busy, l_done;
  logic [1:0] m_state, l_state;

  serial_pattern_tx #(.DW(DW), .GAP(GAP), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_ready),
    .in_data(in_data), .in_len(in_len), .ser_out(m_out), .ser_valid(m_valid),
    .busy(m_busy), .done(m_done), .dbg_state(m_state)
  );

  serial_pattern_tx #(.DW(DW), .GAP(GAP), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_ready),
    .in_data(in_data), .in_len(in_len), .ser_out(l_out), .ser_valid(l_valid),
    .busy(l_busy), .done(l_done), .dbg_state(l_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle-independent rules, both instances.
  task automatic chk_invariants();
    chk("inv_m_out_idle", (!m_valid && m_out) ? 1 : 0, 0);
    chk("inv_l_out_idle", (!l_valid && l_out) ? 1 : 0, 0);
    chk("inv_m_done_valid", (m_done && m_valid) ? 1 : 0, 0);
    chk("inv_l_done_valid", (l_done && l_valid) ? 1 : 0, 0);
    chk("inv_m_ready", m_ready, !m_busy);
    chk("inv_l_ready", l_ready, !l_busy);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_busy"}, m_busy, 0);
    chk({tag, "_m_ready"}, m_ready, 1);
    chk({tag, "_m_done"}, m_done, 0);
    chk({tag, "_l_valid"}, l_valid, 0);
    chk({tag, "_l_busy"}, l_busy, 0);
    chk({tag, "_l_ready"}, l_ready, 1);
    chk({tag, "_l_done"}, l_done, 0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick();
      chk_quiet("idle");
    end
  endtask

  // Present a frame for one edge, then check the whole frame cycle by cycle.
  // Leaves the bench in the done cycle so a following call is back-to-back.
  // hold: keep in_valid high with (d2,len2) during the frame.
  // abort_at: cycle in which rst is pulsed (0 = no abort).
  task automatic send(input logic [DW-1:0] d, input int len_in,
                      input bit hold, input logic [DW-1:0] d2, input int len2,
                      input int abort_at);
    int L;
    logic exp_m[$];
    logic exp_l[$];
    L = (len_in > DW) ? DW : len_in;
    for (int i = 0; i < L; i++) begin
      exp_m.push_back(d[L-1-i]);
      exp_l.push_back(d[i]);
    end

    in_valid = 1'b1;
    in_data  = d;
    in_len   = LW'(len_in);
    tick();
    if (hold) begin
      in_data = d2;
      in_len  = LW'(len2);
    end else begin
      in_valid = 1'b0;
      in_data  = DW'($urandom);
      in_len   = LW'($urandom_range(0, 31));
    end

    for (int c = 1; c <= L + GAP + 1; c++) begin
      chk("m_valid", m_valid, (c <= L) ? 1 : 0);
      chk("l_valid", l_valid, (c <= L) ? 1 : 0);
      chk("m_bit", m_out, (c <= L) ? exp_m[c-1] : 1'b0);
      chk("l_bit", l_out, (c <= L) ? exp_l[c-1] : 1'b0);
      chk("m_busy", m_busy, (c <= L + GAP) ? 1 : 0);
      chk("l_busy", l_busy, (c <= L + GAP) ? 1 : 0);
      chk("m_done", m_done, (c == L + GAP + 1) ? 1 : 0);
      chk("l_done", l_done, (c == L + GAP + 1) ? 1 : 0);
      chk("m_ready", m_ready, (c == L + GAP + 1) ? 1 : 0);
      chk_invariants();
      if (c == abort_at) begin
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk_quiet("abort");
        for (int k = 0; k < L + GAP + 2; k++) begin
          tick();
          chk_quiet("post_abort");
        end
        return;
      end
      if (c < L + GAP + 1) tick();
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    // Reset, with in_valid asserted to show reset wins.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    in_len   = 5'd8;
    tick();
    tick();
    in_valid = 1'b0;
    rst      = 1'b0;
    chk_quiet("reset");
    chk("reset_m_out", m_out, 0);
    chk("reset_l_out", l_out, 0);
    idle(2);

    // 0xB5, 8 bits: MSB 1,0,1,1,0,1,0,1 / LSB 1,0,1,0,1,1,0,1, done at 11.
    send(16'h00B5, 8, 1'b0, '0, 0, 0);
    idle(1);

    // Zero-length frame: only the gap, done at cycle 3.
    send(16'hFFFF, 0, 1'b0, '0, 0, 0);
    idle(1);

    // Over-long length clamps to 16 bits, done at cycle 19.
    send(16'hFFFF, 20, 1'b0, '0, 0, 0);
    idle(1);

    // Second request held during the first frame: taken in the done cycle.
    send(16'h00B5, 8, 1'b1, 16'h000A, 4, 0);
    send(16'h000A, 4, 1'b0, '0, 0, 0);
    idle(1);

    // Reset in cycle 4 of an 8-bit frame, then a normal frame.
    send(16'h00C3, 8, 1'b0, '0, 0, 4);
    send(16'h00C3, 8, 1'b0, '0, 0, 0);
    idle(1);

    // Random frames with random spacing (0 = back-to-back).
    for (int f = 0; f < 30; f++) begin
      int sp;
      send(DW'($urandom), int'($urandom_range(0, 20)), 1'b0, '0, 0, 0);
      sp = int'($urandom_range(0, 2));
      if (sp > 0) idle(sp);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
